// File: rtl/tx_slot_writer.sv
// Frame producer for the GMII TX slot ring: stores length, timestamp, hash and
// payload for one frame, then publishes mem_wr_ptr once the whole frame is written.
module tx_slot_writer #(
  parameter int MIN_FRAME_LEN = 14,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_frame_len,
  input  logic [63:0] cmd_timestamp,
  input  logic [31:0] cmd_hash,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [15:0] data,
  output logic [13:0] slot_tx_eth_addr,
  output logic [15:0] slot_tx_eth_data,
  output logic [1:0]  slot_tx_eth_byte_en,
  output logic        slot_tx_eth_en,
  output logic        slot_tx_eth_wr_en,
  input  logic [13:0] mem_rd_ptr,
  output logic [13:0] mem_wr_ptr,
  output logic [31:0] frame_count,
  output logic [15:0] drop_count,
  output logic        len_err
);

  localparam logic [15:0] MIN_L = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_FRAME_LEN);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_HDR, S_DATA, S_COMMIT, S_DROP} state_t;

  typedef struct packed {
    logic [15:0] len;
    logic [63:0] ts;
    logic [31:0] hash;
  } cmd_t;

  state_t      state;
  cmd_t        cmd;
  logic [13:0] wp;
  logic [2:0]  hdr_idx;
  logic [15:0] rem;
  logic [15:0] hdr_word;

  // Payload word count; 17-bit sum so len = FFFF does not wrap to zero words.
  logic [16:0] len_p1;
  logic [15:0] pwords;
  logic [16:0] need;
  logic [13:0] free;
  logic        len_bad;
  logic        accept;
  logic        last;

  assign len_p1  = 17'(cmd.len) + 17'd1;
  assign pwords  = len_p1[16:1];
  assign need    = 17'd7 + 17'(pwords);
  assign free    = mem_rd_ptr - mem_wr_ptr - 14'd1;
  assign len_bad = (cmd.len < MIN_L) || (cmd.len > MAX_L);
  assign accept  = data_valid & data_ready;
  assign last    = (rem == 16'd1);

  always_comb begin
    hdr_word = cmd.len;
    case (hdr_idx)
      3'd1:    hdr_word = cmd.ts[63:48];
      3'd2:    hdr_word = cmd.ts[47:32];
      3'd3:    hdr_word = cmd.ts[31:16];
      3'd4:    hdr_word = cmd.ts[15:0];
      3'd5:    hdr_word = cmd.hash[31:16];
      3'd6:    hdr_word = cmd.hash[15:0];
      default: hdr_word = cmd.len;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state               <= S_IDLE;
      cmd                 <= '0;
      wp                  <= '0;
      hdr_idx             <= '0;
      rem                 <= '0;
      cmd_ready           <= 1'b0;
      data_ready          <= 1'b0;
      slot_tx_eth_addr    <= '0;
      slot_tx_eth_data    <= '0;
      slot_tx_eth_byte_en <= '0;
      slot_tx_eth_en      <= 1'b0;
      slot_tx_eth_wr_en   <= 1'b0;
      mem_wr_ptr          <= '0;
      frame_count         <= '0;
      drop_count          <= '0;
      len_err             <= 1'b0;
    end else begin
      slot_tx_eth_en    <= 1'b0;
      slot_tx_eth_wr_en <= 1'b0;
      len_err           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd       <= '{len: cmd_frame_len, ts: cmd_timestamp, hash: cmd_hash};
            wp        <= mem_wr_ptr;
            cmd_ready <= 1'b0;
            state     <= S_CHECK;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_CHECK: begin
          rem     <= pwords;
          hdr_idx <= '0;
          if (len_bad) begin
            len_err    <= 1'b1;
            data_ready <= (pwords != 16'd0);
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            state      <= S_DROP;
          end else if ({3'b000, free} >= need) begin
            state <= S_HDR;
          end
        end
        S_HDR: begin
          slot_tx_eth_addr    <= wp;
          slot_tx_eth_data    <= hdr_word;
          slot_tx_eth_byte_en <= 2'b11;
          slot_tx_eth_en      <= 1'b1;
          slot_tx_eth_wr_en   <= 1'b1;
          wp                  <= wp + 14'd1;
          hdr_idx             <= hdr_idx + 3'd1;
          if (hdr_idx == 3'd6) begin
            if (rem == 16'd0) state <= S_COMMIT;
            else begin
              data_ready <= 1'b1;
              state      <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            slot_tx_eth_addr  <= wp;
            slot_tx_eth_en    <= 1'b1;
            slot_tx_eth_wr_en <= 1'b1;
            // Odd-length tail carries only the earlier (high) byte.
            if (last && cmd.len[0]) begin
              slot_tx_eth_data    <= {data[15:8], 8'h00};
              slot_tx_eth_byte_en <= 2'b10;
            end else begin
              slot_tx_eth_data    <= data;
              slot_tx_eth_byte_en <= 2'b11;
            end
            wp  <= wp + 14'd1;
            rem <= rem - 16'd1;
            if (last) begin
              data_ready <= 1'b0;
              state      <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          mem_wr_ptr  <= wp;
          frame_count <= frame_count + 32'd1;
          cmd_ready   <= 1'b1;
          state       <= S_IDLE;
        end
        S_DROP: begin
          if (rem == 16'd0) begin
            data_ready <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= S_IDLE;
          end else if (accept) begin
            rem <= rem - 16'd1;
            if (last) begin
              data_ready <= 1'b0;
              cmd_ready  <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_slot_writer.sv
// Directed bench for tx_slot_writer: slot layout, odd tails, ring backpressure,
// wrap-around, length drops and reset mid-frame.
module tb_tx_slot_writer;
  logic        gmii_tx_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_frame_len;
  logic [63:0] cmd_timestamp;
  logic [31:0] cmd_hash;
  logic        data_valid, data_ready;
  logic [15:0] data;
  logic [13:0] slot_tx_eth_addr;
  logic [15:0] slot_tx_eth_data;
  logic [1:0]  slot_tx_eth_byte_en;
  logic        slot_tx_eth_en, slot_tx_eth_wr_en;
  logic [13:0] mem_rd_ptr, mem_wr_ptr;
  logic [31:0] frame_count;
  logic [15:0] drop_count;
  logic        len_err;

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  tx_slot_writer dut (
    .gmii_tx_clk(gmii_tx_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_frame_len(cmd_frame_len),
    .cmd_timestamp(cmd_timestamp), .cmd_hash(cmd_hash),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .slot_tx_eth_addr(slot_tx_eth_addr), .slot_tx_eth_data(slot_tx_eth_data),
    .slot_tx_eth_byte_en(slot_tx_eth_byte_en), .slot_tx_eth_en(slot_tx_eth_en),
    .slot_tx_eth_wr_en(slot_tx_eth_wr_en), .mem_rd_ptr(mem_rd_ptr), .mem_wr_ptr(mem_wr_ptr),
    .frame_count(frame_count), .drop_count(drop_count), .len_err(len_err)
  );

  int n_chk = 0, n_fail = 0;
  int en_bad = 0, n_lerr = 0;
  logic [13:0] qa[$];
  logic [15:0] qd[$];
  logic [1:0]  qb[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge gmii_tx_clk) begin
    if (slot_tx_eth_en || slot_tx_eth_wr_en) begin
      qa.push_back(slot_tx_eth_addr);
      qd.push_back(slot_tx_eth_data);
      qb.push_back(slot_tx_eth_byte_en);
    end
    if (slot_tx_eth_en !== slot_tx_eth_wr_en) en_bad++;
    if (len_err) n_lerr++;
  end

  task automatic tick();
    @(posedge gmii_tx_clk);
    #1;
  endtask

  task automatic qclear();
    qa.delete(); qd.delete(); qb.delete();
  endtask

  task automatic send_cmd(input logic [15:0] len, input logic [63:0] ts, input logic [31:0] hash);
    int n = 0;
    cmd_valid = 1'b1; cmd_frame_len = len; cmd_timestamp = ts; cmd_hash = hash;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (!cmd_ready) chk("cmd_timeout", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_data(input int nw, input logic [15:0] base);
    for (int i = 0; i < nw; i++) begin
      int n = 0;
      data_valid = 1'b1;
      data = base + 16'(i);
      while (!data_ready && n < 100) begin tick(); n++; end
      if (!data_ready) begin
        chk("data_timeout", 64'(data_ready), 64'd1);
        break;
      end
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] len, input logic [63:0] ts,
                           input logic [31:0] hash, input logic [15:0] base);
    send_cmd(len, ts, hash);
    send_data((int'(len) + 1) / 2, base);
    repeat (3) tick();
  endtask

  task automatic seq_check(input string tag, input logic [13:0] start);
    int bad = 0;
    for (int i = 0; i < qa.size(); i++) if (qa[i] !== start + 14'(i)) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int lat;
    int bad;
    sys_rst = 1'b1; cmd_valid = 1'b0; data_valid = 1'b0; data = '0;
    cmd_frame_len = '0; cmd_timestamp = '0; cmd_hash = '0; mem_rd_ptr = '0;
    repeat (3) tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_ptr_cnt", 64'({mem_wr_ptr, drop_count, data_ready, len_err}), 64'd0);
    chk("rst_slot", 64'({slot_tx_eth_addr, slot_tx_eth_data, slot_tx_eth_byte_en,
                         slot_tx_eth_en, slot_tx_eth_wr_en, frame_count}), 64'd0);
    sys_rst = 1'b0;
    repeat (2) tick();
    qclear();

    // Basic 60-byte frame, with end-to-end latency from command accept to commit.
    send_cmd(16'd60, 64'd0, 32'hDEADBEEF);
    lat = 0;
    fork
      send_data(30, 16'h0001);
      while (mem_wr_ptr == 14'd0 && lat < 200) begin tick(); lat++; end
    join
    repeat (2) tick();
    chk("basic_latency", 64'(lat), 64'd39);
    chk("basic_nwr", 64'(qa.size()), 64'd37);
    seq_check("basic_addr", 14'd0);
    chk("basic_w0", 64'(qd[0]), 64'h003C);
    chk("basic_w5", 64'(qd[5]), 64'hDEAD);
    chk("basic_w6", 64'(qd[6]), 64'hBEEF);
    chk("basic_p0", 64'(qd[7]), 64'h0001);
    chk("basic_plast", 64'(qd[36]), 64'h001E);
    bad = 0;
    for (int i = 0; i < qb.size(); i++) if (qb[i] !== 2'b11) bad++;
    chk("basic_be", 64'(bad), 64'd0);
    chk("basic_ptr", 64'(mem_wr_ptr), 64'd37);
    chk("basic_fc", 64'(frame_count), 64'd1);

    // Odd length: header fields and half-word tail.
    qclear();
    run_frame(16'd61, 64'h1122334455667788, 32'h01234567, 16'hA100);
    chk("odd_nwr", 64'(qa.size()), 64'd38);
    seq_check("odd_addr", 14'd37);
    chk("odd_w1", 64'(qd[1]), 64'h1122);
    chk("odd_w2", 64'(qd[2]), 64'h3344);
    chk("odd_w4", 64'(qd[4]), 64'h7788);
    chk("odd_w5", 64'(qd[5]), 64'h0123);
    chk("odd_w6", 64'(qd[6]), 64'h4567);
    chk("odd_pen_be", 64'(qb[36]), 64'd3);
    chk("odd_tail_be", 64'(qb[37]), 64'd2);
    chk("odd_tail_data", 64'(qd[37]), 64'hA100);
    chk("odd_ptr", 64'(mem_wr_ptr), 64'd75);
    chk("odd_fc", 64'(frame_count), 64'd2);

    // Length limits: drops consume payload without writing, 14 bytes is accepted.
    qclear(); n_lerr = 0;
    send_cmd(16'd10, 64'd0, 32'd0);
    send_data(5, 16'h0050);
    chk("drop10_dready", 64'(data_ready), 64'd0);
    repeat (3) tick();
    chk("drop10_nwr", 64'(qa.size()), 64'd0);
    chk("drop10_cnt", 64'(drop_count), 64'd1);
    chk("drop10_ptr", 64'(mem_wr_ptr), 64'd75);
    chk("drop10_lerr", 64'(n_lerr), 64'd1);
    run_frame(16'd2000, 64'd0, 32'd0, 16'h0000);
    chk("drop2000_cnt", 64'(drop_count), 64'd2);
    run_frame(16'd14, 64'd5, 32'd6, 16'h0700);
    chk("len14_ptr", 64'(mem_wr_ptr), 64'd89);
    chk("len14_fc", 64'(frame_count), 64'd3);
    qclear();
    run_frame(16'd13, 64'd0, 32'd0, 16'h0000);
    run_frame(16'd1519, 64'd0, 32'd0, 16'h0000);
    chk("drop_hi_nwr", 64'(qa.size()), 64'd0);
    chk("drop_hi_cnt", 64'(drop_count), 64'd4);
    chk("drop_hi_ptr", 64'(mem_wr_ptr), 64'd89);
    chk("drop_lerr", 64'(n_lerr), 64'd4);
    chk("drop_fc", 64'(frame_count), 64'd3);

    // Backpressure: 21 max frames fit with rd_ptr at 0, the 22nd waits for space.
    sys_rst = 1'b1; tick(); sys_rst = 1'b0; mem_rd_ptr = '0; repeat (2) tick();
    for (int f = 0; f < 21; f++) run_frame(16'd1518, 64'(f), 32'(f), 16'(f * 16));
    chk("bp_fc21", 64'(frame_count), 64'd21);
    chk("bp_ptr21", 64'(mem_wr_ptr), 64'd16086);
    send_cmd(16'd1518, 64'd0, 32'd0);
    data_valid = 1'b1; data = 16'hBEEF;
    repeat (20) tick();
    chk("bp_stall_cready", 64'(cmd_ready), 64'd0);
    chk("bp_stall_dready", 64'(data_ready), 64'd0);
    chk("bp_stall_ptr", 64'(mem_wr_ptr), 64'd16086);
    mem_rd_ptr = 14'd800;
    send_data(759, 16'h1000);
    repeat (3) tick();
    chk("bp_ptr22", 64'(mem_wr_ptr), 64'd468);
    chk("bp_fc22", 64'(frame_count), 64'd22);

    // Wrap-around: walk the write pointer to 3FF0 with rd_ptr following.
    sys_rst = 1'b1; tick(); sys_rst = 1'b0; mem_rd_ptr = '0; repeat (2) tick();
    for (int f = 0; f < 21; f++) begin
      run_frame(16'd1518, 64'd0, 32'd0, 16'h0000);
      mem_rd_ptr = mem_wr_ptr;
    end
    run_frame(16'd550, 64'd0, 32'd0, 16'h0000);
    chk("wrap_pre", 64'(mem_wr_ptr), 64'h3FF0);
    mem_rd_ptr = mem_wr_ptr;
    qclear();
    run_frame(16'd64, 64'd0, 32'hCAFEF00D, 16'h0100);
    chk("wrap_nwr", 64'(qa.size()), 64'd39);
    chk("wrap_a15", 64'(qa[15]), 64'h3FFF);
    chk("wrap_a16", 64'(qa[16]), 64'h0000);
    chk("wrap_alast", 64'(qa[38]), 64'h0016);
    chk("wrap_plast", 64'(qd[38]), 64'h011F);
    chk("wrap_ptr", 64'(mem_wr_ptr), 64'h0017);

    // Reset mid-frame, then a fresh frame starts at address 0.
    mem_rd_ptr = mem_wr_ptr;
    send_cmd(16'd60, 64'd0, 32'd0);
    send_data(10, 16'h2000);
    data_valid = 1'b1;
    sys_rst = 1'b1;
    #1;
    chk("midrst_ptr_cnt", 64'({mem_wr_ptr, frame_count, drop_count}), 64'd0);
    chk("midrst_hs", 64'({cmd_ready, data_ready, len_err}), 64'd0);
    chk("midrst_slot", 64'({slot_tx_eth_addr, slot_tx_eth_data, slot_tx_eth_byte_en,
                            slot_tx_eth_en, slot_tx_eth_wr_en}), 64'd0);
    data_valid = 1'b0; mem_rd_ptr = '0;
    tick(); sys_rst = 1'b0; repeat (2) tick();
    qclear();
    run_frame(16'd60, 64'd0, 32'hDEADBEEF, 16'h0001);
    chk("post_nwr", 64'(qa.size()), 64'd37);
    seq_check("post_addr", 14'd0);
    chk("post_ptr", 64'(mem_wr_ptr), 64'd37);
    chk("en_eq_wr_en", 64'(en_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
